// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: handshake and control bundle between the instruction path and the sequencer.
interface ctrl_sequencer_if #(parameter int CODE_W = 3);
    logic              start;
    logic [CODE_W-1:0] code;
    logic              mem_ready;
    logic [4:0]        state;
    logic              fetch_en;
    logic              load_en;
    logic              mov_en;
    logic              alu_en;
    logic [1:0]        alu_op;
    logic [3:0]        alu_stage;
    logic              instr_done;
    logic              illegal;
    logic              err_sticky;
    logic              busy;
    modport master (
        output start, code, mem_ready,
        input  state, fetch_en, load_en, mov_en, alu_en, alu_op, alu_stage,
               instr_done, illegal, err_sticky, busy
    );
    modport slave (
        input  start, code, mem_ready,
        output state, fetch_en, load_en, mov_en, alu_en, alu_op, alu_stage,
               instr_done, illegal, err_sticky, busy
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: registered CPU control FSM with memory stalls, multi-cycle ALU execute and illegal-opcode flagging.
module ctrl_sequencer #(
    parameter int CODE_W     = 3,
    parameter int ALU_STAGES = 3
) (
    input logic            clk,
    input logic            rst,
    ctrl_sequencer_if.slave bus
);
    localparam logic [4:0] S_IDLE   = 5'b11111;
    localparam logic [4:0] S_FETCH  = 5'b10000;
    localparam logic [4:0] S_DECODE = 5'b00000;
    localparam logic [4:0] S_LOAD   = 5'b00001;
    localparam logic [4:0] S_MOV    = 5'b00010;
    localparam logic [4:0] S_EXEC   = 5'b00011;
    localparam logic [3:0] LAST     = 4'(ALU_STAGES - 1);
    logic [4:0] st, nx;
    logic [3:0] cnt;
    logic [1:0] op;
    logic       err;
    logic       bad_code, halt_code, alu_code, exec_last;
    assign bad_code  = bus.code > CODE_W'(6);
    assign halt_code = bus.code == CODE_W'(6);
    assign alu_code  = bus.code >= CODE_W'(2) && bus.code <= CODE_W'(5);
    assign exec_last = st == S_EXEC && cnt == LAST;
    always_comb begin
        nx = S_IDLE;
        case (st)
            S_IDLE:   nx = bus.start ? S_FETCH : S_IDLE;
            S_FETCH:  nx = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: nx = bus.code == CODE_W'(0) ? S_LOAD :
                           bus.code == CODE_W'(1) ? S_MOV :
                           alu_code ? S_EXEC :
                           halt_code ? S_IDLE : S_FETCH;
            S_LOAD:   nx = bus.mem_ready ? S_FETCH : S_LOAD;
            S_MOV:    nx = S_FETCH;
            S_EXEC:   nx = exec_last ? S_FETCH : S_EXEC;
            default:  nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= S_IDLE;
            cnt <= '0;
            op  <= '0;
            err <= 1'b0;
        end else begin
            st  <= nx;
            cnt <= (st == S_EXEC && !exec_last) ? cnt + 4'd1 : 4'd0;
            if (st == S_DECODE && alu_code)
                op <= bus.code[1:0] - 2'd2;
            if (st == S_DECODE && bad_code)
                err <= 1'b1;
        end
    end
    assign bus.state      = st;
    assign bus.fetch_en   = st == S_FETCH;
    assign bus.load_en    = st == S_LOAD;
    assign bus.mov_en     = st == S_MOV;
    assign bus.alu_en     = st == S_EXEC;
    assign bus.alu_op     = st == S_EXEC ? op : 2'd0;
    assign bus.alu_stage  = st == S_EXEC ? cnt : 4'd0;
    // LOAD completion follows mem_ready combinationally; HALT completes in DECODE.
    assign bus.instr_done = (st == S_LOAD && bus.mem_ready) || st == S_MOV || exec_last ||
                            (st == S_DECODE && halt_code);
    assign bus.illegal    = st == S_DECODE && bad_code;
    assign bus.err_sticky = err;
    assign bus.busy       = st != S_IDLE;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed vectors checking every output of ctrl_sequencer cycle by cycle.
module tb_ctrl_sequencer;
    localparam logic [4:0] I = 5'b11111, F = 5'b10000, D = 5'b00000;
    localparam logic [4:0] L = 5'b00001, M = 5'b00010, E = 5'b00011;
    logic clk = 1'b0;
    logic rst;
    int n_tests = 0;
    int n_fail  = 0;
    ctrl_sequencer_if #(.CODE_W(3)) bus ();
    ctrl_sequencer #(.CODE_W(3), .ALU_STAGES(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    logic [18:0] outs;
    assign outs = {bus.state, bus.fetch_en, bus.load_en, bus.mov_en, bus.alu_en, bus.alu_op,
                   bus.alu_stage, bus.instr_done, bus.illegal, bus.err_sticky, bus.busy};
    function automatic logic [18:0] ev(input logic [4:0] s, input logic f, l, m, a,
                                       input logic [1:0] op, input logic [3:0] stg,
                                       input logic d, il, er, b);
        return {s, f, l, m, a, op, stg, d, il, er, b};
    endfunction
    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask
    // Settle combinational outputs for the current inputs, compare, then advance one clock.
    task automatic cyc(input string tag, input logic [18:0] exp);
        #1 check(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.code = 3'd0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc("reset_idle", ev(I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.start = 1'b1; bus.mem_ready = 1'b1; bus.code = 3'd2;
        cyc("t2_idle_start", ev(I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        bus.start = 1'b0;
        cyc("t2_fetch", ev(F, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc("t2_decode", ev(D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc("t2_ex0", ev(E, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        cyc("t2_ex1", ev(E, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
        bus.mem_ready = 1'b0;
        cyc("t2_ex2", ev(E, 0, 0, 0, 1, 0, 2, 1, 0, 0, 1));
        bus.start = 1'b1;
        for (int k = 0; k < 4; k++)
            cyc($sformatf("t3_fetch_stall%0d", k), ev(F, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        bus.start = 1'b0; bus.mem_ready = 1'b1;
        cyc("t3_fetch_go", ev(F, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        bus.code = 3'd0; bus.mem_ready = 1'b0;
        cyc("t3_decode", ev(D, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        bus.code = 3'd7;
        cyc("t3_load_stall0", ev(L, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc("t3_load_stall1", ev(L, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        bus.mem_ready = 1'b1;
        cyc("t3_load_done", ev(L, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        cyc("t4_fetch", ev(F, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        cyc("t4_decode_illegal", ev(D, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        bus.code = 3'd1;
        cyc("t4_fetch_after", ev(F, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        cyc("t4_decode_mov", ev(D, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        bus.code = 3'd6;
        cyc("t4_mov", ev(M, 0, 0, 1, 0, 0, 0, 1, 0, 1, 1));
        cyc("t5_fetch", ev(F, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        cyc("t5_decode_halt", ev(D, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        bus.start = 1'b0;
        cyc("t5_idle0", ev(I, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        bus.start = 1'b1; bus.code = 3'd5;
        cyc("t5_idle1", ev(I, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        bus.start = 1'b0;
        cyc("and_fetch", ev(F, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        cyc("and_decode", ev(D, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        bus.code = 3'd4;
        cyc("and_ex0", ev(E, 0, 0, 0, 1, 3, 0, 0, 0, 1, 1));
        cyc("and_ex1", ev(E, 0, 0, 0, 1, 3, 1, 0, 0, 1, 1));
        cyc("and_ex2", ev(E, 0, 0, 0, 1, 3, 2, 1, 0, 1, 1));
        cyc("t6_fetch", ev(F, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        cyc("t6_decode_or", ev(D, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        cyc("t6_ex0", ev(E, 0, 0, 0, 1, 2, 0, 0, 0, 1, 1));
        rst = 1'b1; bus.start = 1'b1;
        cyc("t6_ex1_rst", ev(E, 0, 0, 0, 1, 2, 1, 0, 0, 1, 1));
        rst = 1'b0; bus.start = 1'b0;
        cyc("t6_after_rst", ev(I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("t6_idle_hold", ev(I, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
